// File: rtl/vector_sequencer.sv
// Applies one test vector to the part, waits SETTLE cycles, captures the synchronised
// primary outputs, compares them against masked expectations and hands back a result.
//
// state | meaning
// IDLE  | ready for a vector; part_pis_o holds the last applied stimulus
// WAIT  | stimulus applied, counting settle plus synchroniser latency
// RESP  | result presented on res_*, waiting for res_ready_i
module vector_sequencer #(
    parameter int NPIS   = 14,
    parameter int NPOS   = 11,
    parameter int SETTLE = 4,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            vec_valid_i,
    output logic            vec_ready_o,
    input  logic [NPIS-1:0] vec_pis_i,
    input  logic [NPOS-1:0] vec_exp_i,
    input  logic [NPOS-1:0] vec_mask_i,
    output logic [NPIS-1:0] part_pis_o,
    input  logic [NPOS-1:0] part_pos_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [NPOS-1:0] res_pos_o,
    output logic [NPOS-1:0] res_diff_o,
    output logic            res_fail_o,
    output logic [CNTW-1:0] vec_cnt_o,
    output logic [CNTW-1:0] fail_cnt_o,
    output logic            busy_o
);

    // Capture happens SETTLE+2 edges after acceptance: SETTLE plus two synchroniser stages.
    localparam int            WW     = $clog2(SETTLE + 2);
    localparam logic [WW-1:0] CAP_AT = WW'(SETTLE + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [NPOS-1:0] sync1_q, sync2_q;
    logic [NPIS-1:0] pis_q, pis_d;
    logic [NPOS-1:0] exp_q, exp_d;
    logic [NPOS-1:0] mask_q, mask_d;
    logic [NPOS-1:0] rpos_q, rpos_d;
    logic [NPOS-1:0] rdiff_q, rdiff_d;
    logic            rfail_q, rfail_d;
    logic [CNTW-1:0] vcnt_q, vcnt_d;
    logic [CNTW-1:0] fcnt_q, fcnt_d;
    logic            handshake;
    logic [NPOS-1:0] diff_c;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        pis_d     = pis_q;
        exp_d     = exp_q;
        mask_d    = mask_q;
        rpos_d    = rpos_q;
        rdiff_d   = rdiff_q;
        rfail_d   = rfail_q;
        handshake = 1'b0;
        diff_c    = (sync2_q ^ exp_q) & mask_q;
        case (state_q)
            ST_IDLE: begin
                if (vec_valid_i) begin
                    pis_d   = vec_pis_i;
                    exp_d   = vec_exp_i;
                    mask_d  = vec_mask_i;
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == CAP_AT) begin
                    rpos_d  = sync2_q;
                    rdiff_d = diff_c;
                    rfail_d = |diff_c;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_RESP: begin
                if (res_ready_i) begin
                    handshake = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating counters; clear overrides a coincident handshake.
    always_comb begin
        vcnt_d = vcnt_q;
        fcnt_d = fcnt_q;
        if (clear_i) begin
            vcnt_d = '0;
            fcnt_d = '0;
        end else if (handshake) begin
            if (vcnt_q != '1) begin
                vcnt_d = vcnt_q + CNTW'(1);
            end
            if (rfail_q && (fcnt_q != '1)) begin
                fcnt_d = fcnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            pis_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            rpos_q  <= '0;
            rdiff_q <= '0;
            rfail_q <= 1'b0;
            vcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            sync1_q <= part_pos_i;
            sync2_q <= sync1_q;
            pis_q   <= pis_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            rpos_q  <= rpos_d;
            rdiff_q <= rdiff_d;
            rfail_q <= rfail_d;
            vcnt_q  <= vcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign vec_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign res_valid_o = (state_q == ST_RESP);
    assign part_pis_o  = pis_q;
    assign res_pos_o   = rpos_q;
    assign res_diff_o  = rdiff_q;
    assign res_fail_o  = rfail_q;
    assign vec_cnt_o   = vcnt_q;
    assign fail_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: timestamp-based reference model checked every cycle on a
// SETTLE=4/CNTW=4 instance, plus directed checks on a SETTLE=0 instance.
module tb_vector_sequencer;

    localparam int S    = 4;
    localparam int MAXC = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_i, vec_valid_i, res_ready_i;
    logic [13:0] vec_pis_i;
    logic [10:0] vec_exp_i, vec_mask_i, part_pos_i;
    logic        vec_ready_o, res_valid_o, res_fail_o, busy_o;
    logic [13:0] part_pis_o;
    logic [10:0] res_pos_o, res_diff_o;
    logic [3:0]  vec_cnt_o, fail_cnt_o;

    logic        clear0, vec_valid0, res_ready0;
    logic [13:0] vec_pis0;
    logic [10:0] vec_exp0, vec_mask0, part_pos0;
    logic        vec_ready0, res_valid0, res_fail0, busy0;
    logic [13:0] part_pis0;
    logic [10:0] res_pos0, res_diff0;
    logic [15:0] vec_cnt0, fail_cnt0;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vector_sequencer #(.NPIS(14), .NPOS(11), .SETTLE(S), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o),
        .vec_pis_i(vec_pis_i), .vec_exp_i(vec_exp_i), .vec_mask_i(vec_mask_i),
        .part_pis_o(part_pis_o), .part_pos_i(part_pos_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_pos_o(res_pos_o), .res_diff_o(res_diff_o), .res_fail_o(res_fail_o),
        .vec_cnt_o(vec_cnt_o), .fail_cnt_o(fail_cnt_o), .busy_o(busy_o)
    );

    vector_sequencer #(.NPIS(14), .NPOS(11), .SETTLE(0), .CNTW(16)) dut0 (
        .clk(clk), .rst(rst), .clear_i(clear0),
        .vec_valid_i(vec_valid0), .vec_ready_o(vec_ready0),
        .vec_pis_i(vec_pis0), .vec_exp_i(vec_exp0), .vec_mask_i(vec_mask0),
        .part_pis_o(part_pis0), .part_pos_i(part_pos0),
        .res_valid_o(res_valid0), .res_ready_i(res_ready0),
        .res_pos_o(res_pos0), .res_diff_o(res_diff0), .res_fail_o(res_fail0),
        .vec_cnt_o(vec_cnt0), .fail_cnt_o(fail_cnt0), .busy_o(busy0)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: a vector accepted at edge e0 reports the PO value seen at edge
    // e0+S, and its result appears at edge e0+S+2.
    logic [10:0] hist [16];
    bit          m_act = 1'b0, m_resp = 1'b0, m_rfail = 1'b0;
    int          m_e0 = 0, m_vc = 0, m_fc = 0;
    logic [13:0] m_pis = '0;
    logic [10:0] m_exp = '0, m_mask = '0, m_rpos = '0, m_rdiff = '0;

    always @(posedge clk) begin
        hist[cyc % 16] = part_pos_i;
        if (rst) begin
            m_act = 0; m_resp = 0; m_pis = '0; m_rpos = '0; m_rdiff = '0; m_rfail = 0;
            m_vc = 0; m_fc = 0;
        end else begin
            if (!m_act) begin
                if (vec_valid_i) begin
                    m_act = 1; m_e0 = cyc;
                    m_pis = vec_pis_i; m_exp = vec_exp_i; m_mask = vec_mask_i;
                end
            end else if (!m_resp) begin
                if (cyc == m_e0 + S + 2) begin
                    m_rpos  = hist[(m_e0 + S) % 16];
                    m_rdiff = (m_rpos ^ m_exp) & m_mask;
                    m_rfail = (m_rdiff != 0);
                    m_resp  = 1;
                end
            end else if (res_ready_i) begin
                m_act = 0; m_resp = 0;
                if (m_vc < MAXC) m_vc++;
                if (m_rfail && m_fc < MAXC) m_fc++;
            end
            if (clear_i) begin m_vc = 0; m_fc = 0; end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vec_ready", vec_ready_o, m_act ? 0 : 1);
            chk("busy", busy_o, m_act);
            chk("res_valid", res_valid_o, m_resp);
            chk("part_pis", part_pis_o, m_pis);
            chk("res_pos", res_pos_o, m_rpos);
            chk("res_diff", res_diff_o, m_rdiff);
            chk("res_fail", res_fail_o, m_rfail);
            chk("vec_cnt", vec_cnt_o, m_vc);
            chk("fail_cnt", fail_cnt_o, m_fc);
        end
    end

    task automatic send_vec(input logic [13:0] pis, input logic [10:0] exp, input logic [10:0] mask,
                            input logic [10:0] pos, input int hold, input bit poke, input bit clr_hs,
                            output int lat, output logic [10:0] r_pos, output logic [10:0] r_diff,
                            output logic r_fail);
        int n, t0;
        logic [10:0] held;
        n = 0;
        while (!vec_ready_o && n < 50) begin @(negedge clk); n++; end
        chk("ready_wait", (n < 50) ? 1 : 0, 1);
        vec_valid_i = 1; vec_pis_i = pis; vec_exp_i = exp; vec_mask_i = mask;
        @(negedge clk);
        t0 = cyc;
        chk("pis_applied", part_pis_o, pis);
        vec_valid_i = 0; vec_pis_i = 14'($urandom); vec_exp_i = 11'($urandom); vec_mask_i = 11'($urandom);
        part_pos_i = pos;
        n = 0;
        while (!res_valid_o && n < 50) begin @(negedge clk); n++; end
        chk("valid_wait", (n < 50) ? 1 : 0, 1);
        lat = cyc - t0; r_pos = res_pos_o; r_diff = res_diff_o; r_fail = res_fail_o;
        held = res_pos_o;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin vec_valid_i = 1; vec_pis_i = 14'($urandom); part_pos_i = 11'($urandom); end
            @(negedge clk);
            if (poke) begin
                chk("bp_pos_hold", res_pos_o, held);
                chk("bp_ready", vec_ready_o, 0);
            end
        end
        res_ready_i = 1; clear_i = clr_hs;
        @(negedge clk);
        res_ready_i = 0; clear_i = 0; vec_valid_i = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, t, tprev;
        logic [10:0] rp, rd;
        logic rf;
        rst = 1; clear_i = 0; vec_valid_i = 0; res_ready_i = 0;
        vec_pis_i = '0; vec_exp_i = '0; vec_mask_i = '0; part_pos_i = '0;
        clear0 = 0; vec_valid0 = 0; res_ready0 = 0; vec_pis0 = '0; vec_exp0 = '0; vec_mask0 = '0; part_pos0 = '0;
        tprev = 0;
        repeat (2) @(negedge clk);
        rst = 0; chk_en = 1;
        chk("rst_ready", vec_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_pis", part_pis_o, 0);
        chk("rst_vcnt", vec_cnt_o, 0);

        // Matching vector, full mask
        send_vec(14'h1234, 11'h2AB, 11'h7FF, 11'h2AB, 0, 0, 0, lat, rp, rd, rf);
        chk("t1_latency", lat, 6);
        chk("t1_fail", rf, 0);
        chk("t1_diff", rd, 0);
        chk("t1_vcnt", vec_cnt_o, 1);
        chk("t1_fcnt", fail_cnt_o, 0);

        // Single-bit mismatch, compared and then masked off
        send_vec(14'h0001, 11'h2AB, 11'h001, 11'h2AA, 0, 0, 0, lat, rp, rd, rf);
        chk("t2_fail", rf, 1);
        chk("t2_diff", rd, 11'h001);
        chk("t2_pos", rp, 11'h2AA);
        chk("t2_fcnt", fail_cnt_o, 1);
        send_vec(14'h0002, 11'h2AB, 11'h7FE, 11'h2AA, 0, 0, 0, lat, rp, rd, rf);
        chk("t3_fail", rf, 0);
        chk("t3_diff", rd, 0);
        chk("t3_fcnt", fail_cnt_o, 1);
        chk("t3_vcnt", vec_cnt_o, 3);

        // Backpressure with vectors offered and POs moving during RESP
        send_vec(14'h0ABC, 11'h155, 11'h7FF, 11'h154, 10, 1, 0, lat, rp, rd, rf);
        chk("bp_vcnt", vec_cnt_o, 4);
        chk("bp_fcnt", fail_cnt_o, 2);

        // Reset two edges into WAIT aborts the vector
        n = 0;
        while (!vec_ready_o && n < 20) begin @(negedge clk); n++; end
        vec_valid_i = 1; vec_pis_i = 14'h0F0F; vec_exp_i = 11'h0; vec_mask_i = 11'h7FF;
        @(negedge clk);
        vec_valid_i = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rw_pis", part_pis_o, 0);
        chk("rw_ready", vec_ready_o, 1);
        chk("rw_vcnt", vec_cnt_o, 0);
        chk("rw_fcnt", fail_cnt_o, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rw_no_valid", res_valid_o, 0);
        end
        send_vec(14'h3333, 11'h0F0, 11'h7FF, 11'h0F0, 0, 0, 0, lat, rp, rd, rf);
        chk("rw_after_lat", lat, 6);
        chk("rw_after_vcnt", vec_cnt_o, 1);

        // Randomised traffic, including clears and occasional resets
        for (int i = 0; i < 400; i++) begin
            vec_valid_i = ($urandom % 3) != 0;
            vec_pis_i   = 14'($urandom);
            vec_exp_i   = ($urandom % 2) ? 11'h2AB : 11'($urandom);
            vec_mask_i  = ($urandom % 2) ? 11'h7FF : 11'($urandom);
            case ($urandom % 3)
                0: part_pos_i = vec_exp_i;
                1: part_pos_i = vec_exp_i ^ 11'h001;
                default: part_pos_i = 11'($urandom);
            endcase
            res_ready_i = ($urandom % 2) != 0;
            clear_i     = ($urandom % 40) == 0;
            rst         = ($urandom % 150) == 0;
            @(negedge clk);
        end
        rst = 0; vec_valid_i = 0; clear_i = 0; res_ready_i = 1;
        repeat (10) @(negedge clk);
        res_ready_i = 0; clear_i = 1;
        @(negedge clk);
        clear_i = 0;

        // Saturation at 2^CNTW-1, then clear coincident with a handshake
        for (int i = 0; i < 17; i++)
            send_vec(14'(i), 11'h000, 11'h7FF, 11'h7FF, 0, 0, 0, lat, rp, rd, rf);
        chk("sat_vcnt", vec_cnt_o, 15);
        chk("sat_fcnt", fail_cnt_o, 15);
        send_vec(14'h0011, 11'h000, 11'h7FF, 11'h7FF, 2, 0, 1, lat, rp, rd, rf);
        chk("clr_vcnt", vec_cnt_o, 0);
        chk("clr_fcnt", fail_cnt_o, 0);
        chk("clr_idle", busy_o, 0);

        // SETTLE=0 instance: back-to-back vectors every 4 cycles
        res_ready0 = 1; vec_mask0 = 11'h7FF;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!vec_ready0 && n < 20) begin @(negedge clk); n++; end
            chk("s0_ready_wait", (n < 20) ? 1 : 0, 1);
            vec_valid0 = 1; vec_pis0 = 14'(k + 1);
            part_pos0 = 11'(11'h100 + k); vec_exp0 = 11'(11'h100 + k);
            @(negedge clk);
            t = cyc;
            if (k > 0) chk("s0_period", t - tprev, 4);
            tprev = t;
            chk("s0_pis", part_pis0, k + 1);
            part_pos0 = 11'h7FF ^ 11'(11'h100 + k);
            @(negedge clk);
            chk("s0_early", res_valid0, 0);
            @(negedge clk);
            chk("s0_valid", res_valid0, 1);
            chk("s0_pos", res_pos0, 11'h100 + k);
            chk("s0_fail", res_fail0, 0);
            @(negedge clk);
            chk("s0_vcnt", vec_cnt0, k + 1);
            chk("s0_ready", vec_ready0, 1);
        end
        vec_valid0 = 0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Sequences one test vector at a time onto the part under test.
- Per vector: drives the primary inputs, waits a programmable settle time, captures the primary outputs through a synchroniser, compares them against masked expected values, and returns a pass/fail result.
- Sits between the command parser (vector source and result sink) and the part pins. Keeps running vector and fail counters for reporting over the UART.

Parameters:
- NPIS, 14, number of part primary inputs.
- NPOS, 11, number of part primary outputs.
- SETTLE, 4, cycles between PI update and the PO sample point; 0 is legal.
- CNTW, 16, width of the vector and fail counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- clear_i  in  1  zero both counters.
- vec_valid_i  in  1  vector offered.
- vec_ready_o  out  1  sequencer can accept a vector.
- vec_pis_i  in  NPIS  stimulus.
- vec_exp_i  in  NPOS  expected PO values.
- vec_mask_i  in  NPOS  compare enable per PO bit; 1 = compare.
- part_pis_o  out  NPIS  driven PI pins.
- part_pos_i  in  NPOS  PO pins; asynchronous to clk.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumed.
- res_pos_o  out  NPOS  captured PO values.
- res_diff_o  out  NPOS  (captured XOR expected) AND mask.
- res_fail_o  out  1  OR-reduction of res_diff_o.
- vec_cnt_o  out  CNTW  completed vectors.
- fail_cnt_o  out  CNTW  failed vectors.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - part_pis_o, res_pos_o, res_diff_o, res_fail_o, both counters and the synchroniser are set to 0.
  - res_valid_o=0, busy_o=0, vec_ready_o=1.
- Reset mid-operation: the vector is aborted, no result is emitted, part_pis_o returns to 0.
- part_pos_i passes through a 2-flop synchroniser (pos_sync) every cycle, independent of state.
- FSM IDLE:
  - vec_ready_o=1.
  - On vec_valid_i & vec_ready_o at edge E0: part_pis_o <= vec_pis_i; latch exp and mask; wait counter <= 0; go to WAIT.
- FSM WAIT:
  - Counter increments each cycle.
  - At edge E0+SETTLE+2, capture: res_pos_o <= pos_sync; res_diff_o <= (pos_sync ^ exp) & mask; res_fail_o <= |diff; go to RESP.
  - The captured value reflects part_pos_i as sampled at edge E0+SETTLE.
- FSM RESP:
  - res_valid_o=1; res_* outputs are held stable until handshake.
  - On res_valid_o & res_ready_i: vec_cnt_o += 1; fail_cnt_o += res_fail_o; go to IDLE.
  - res_valid_o is 1 from E0+SETTLE+2 until the handshake edge inclusive.
- vec_ready_o is 0 in WAIT and RESP, so there is no pipelining. Minimum period is SETTLE+4 cycles per vector with res_ready_i tied high.
- part_pis_o holds the last applied vector after completion; it is not cleared until the next vector or reset.
- res_* outputs keep their last value after the handshake.
- Counters saturate at 2^CNTW-1 and never wrap.
- clear_i is honoured in any state and zeroes both counters next edge. If it coincides with a result handshake, clear wins (counters = 0) and the FSM still advances to IDLE.
- rst has priority over clear_i and over all handshakes.
- vec_* inputs are ignored outside the accepting edge. Changes to vec_* during WAIT or RESP have no effect.

Test Plan:
- SETTLE=4; vector pis=0x1234, exp=0x2AB, mask=0x7FF; part returns 0x2AB from 1 cycle after the PI update -> part_pis_o=0x1234 at E0; res_valid_o at E0+6; res_fail_o=0, res_diff_o=0; vec_cnt_o=1, fail_cnt_o=0.
- Part returns 0x2AA vs exp 0x2AB with mask 0x001 -> res_fail_o=1, res_diff_o=0x001, fail_cnt_o=1. The same mismatch with mask 0x7FE -> res_fail_o=0, res_diff_o=0.
- Backpressure: res_ready_i held low 10 cycles after res_valid_o -> res_* stable, vec_ready_o=0, a vec_valid_i offered meanwhile is not accepted, counters unchanged until the handshake. Changing part_pos_i during RESP leaves res_pos_o unchanged.
- CNTW=4: 17 consecutive failing vectors -> fail_cnt_o=vec_cnt_o=15 (saturated). Then clear_i coincident with the 18th handshake -> both counters=0, FSM returns to IDLE.
- rst asserted in WAIT at E0+2 -> next cycle part_pis_o=0, res_valid_o never asserts, vec_ready_o=1, counters=0. A subsequent vector completes normally.
- SETTLE=0: back-to-back vectors with res_ready_i=1 -> results at E0+2, accepts every 4 cycles. part_pos_i changing at E0+1 is not reflected in res_pos_o.
